sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single-port SRAM between three burst requesters: image fetch, coefficient fetch
//  and result write-back. Grants one requester at a time by round-robin, runs its burst
//  (address increment, read/write strobes, read-data return) and pulses done on completion.
//  Sits between the detection control FSMs and the SRAM model.
// PARAMETERS
//  NUM_REQ  3   number of requesters (index 0 image, 1 coef, 2 result)
//  ADDR_W   16  SRAM address width
//  DATA_W   16  SRAM word width
//  LEN_W    8   burst length width; length 0..2^LEN_W-1 words
//  RD_LAT   1   SRAM read latency, cycles from sram_ren to valid sram_rdata (>=1)
// PORTS
//  clk          in   1                  system clock, rising edge
//  n_rst        in   1                  asynchronous, active-low reset
//  req          in   NUM_REQ            burst request, held high until matching done
//  req_wr       in   NUM_REQ            1 = write burst, 0 = read burst
//  req_addr     in   NUM_REQ x ADDR_W   burst base address
//  req_len      in   NUM_REQ x LEN_W    burst length in words
//  req_wdata    in   NUM_REQ x DATA_W   write data of each requester
//  grant        out  NUM_REQ            one-hot owner of the SRAM port
//  wr_strobe    out  NUM_REQ            write word consumed this cycle; requester advances wdata
//  rd_valid     out  NUM_REQ            rd_data valid for that requester
//  rd_data      out  DATA_W             read data, broadcast
//  done         out  NUM_REQ            one-cycle burst-complete pulse
//  sram_addr    out  ADDR_W             SRAM address
//  sram_ren     out  1                  SRAM read enable
//  sram_wen     out  1                  SRAM write enable
//  sram_wdata   out  DATA_W             SRAM write data = req_wdata[granted]
//  sram_rdata   in   DATA_W             SRAM read data
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, round-robin pointer = 0, counters 0.
//  - FSM: IDLE -> BURST (any req, len!=0) | DONE (winner len==0); BURST -> DRAIN after last
//    access of a read, -> DONE after last write; DRAIN -> DONE after RD_LAT cycles; DONE -> IDLE.
//  - Arbitration only in IDLE: first req at or after pointer wins; at the winner's latch edge,
//    latch addr/len/wr into internal registers; pointer <= winner+1 (mod NUM_REQ).
//  - Timing (req seen in IDLE at cycle 0): grant one-hot from cycle 1 through last BURST/DRAIN
//    cycle; access k (k=0..len-1) in cycle 1+k, sram_addr = base+k modulo 2^ADDR_W (wraps).
//  - Read: sram_ren=1 each BURST cycle; rd_valid[g]=1 exactly RD_LAT cycles after each
//    sram_ren, rd_data=sram_rdata. Write: sram_wen=1 and wr_strobe[g]=1 each BURST cycle.
//  - DONE: done[g]=1 one cycle, grant=0, no strobes. Read done at cycle len+RD_LAT+1, write at len+1.
//  - len==0: no SRAM strobe, no grant; done pulse in cycle 1.
//  - req deasserted mid-burst: ignored, burst completes, done still pulses.
//  - req held high after done: re-arbitrated in IDLE as a new burst (requester drops req on done).
//  - Requester inputs changing after latch do not affect the running burst except req_wdata.
//  - sram_ren and sram_wen never both 1; grant never multi-hot; one idle cycle between bursts.
//  - Reset asserted mid-burst: immediate return to reset values; pending reads discarded.
// STRUCTURE
//  - Package sram_arb_pkg: state enum {IDLE,BURST,DRAIN,DONE}, REQ_IMAGE=0, REQ_COEF=1,
//    REQ_RESULT=2, default widths.
//  - Sub-module rr_pick: combinational round-robin picker (req vector, pointer -> one-hot, index).
//  - Read-return timing: RD_LAT-deep shift register of {valid, owner}.
// TESTING
//  1. req[0] read addr 0x0100 len 4, RD_LAT=1 -> ren cycles 1-4 addr 0x0100..0x0103,
//     rd_valid[0] cycles 2-5, grant[0] cycles 1-5, done[0] cycle 6.
//  2. req=3'b111 right after reset, each len 2 -> grants in order 0,1,2; then req=3'b011
//     -> pointer 0 again: order 0,1.
//  3. req[2] write addr 0xFFFE len 3 -> wen cycles 1-3 addr 0xFFFE,0xFFFF,0x0000,
//     wr_strobe[2] same cycles, sram_wdata tracks req_wdata[2], done[2] cycle 4.
//  4. req[1] len 0 -> no ren/wen, grant stays 0, done[1] in cycle 1.
//  5. n_rst low in cycle 3 of a len-8 read -> all outputs 0 at once; after release,
//     req=3'b110 -> requester 1 granted first.
//  6. req[0] dropped in cycle 2 of len-5 read -> all 5 reads issued, done[0] in cycle 7.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default sizing for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int REQ_IMAGE  = 0;
    localparam int REQ_COEF   = 1;
    localparam int REQ_RESULT = 2;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_RD_LAT  = 1;

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer wins.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o
);

    int               sum;
    logic [IDX_W-1:0] slot;

    always_comb begin
        any_o    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        sum      = 0;
        slot     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr_i) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            slot = IDX_W'(sum);
            if (!any_o && req_i[slot]) begin
                any_o          = 1'b1;
                onehot_o[slot] = 1'b1;
                idx_o          = slot;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin owner of the single SRAM port: runs one requester's read or write burst at a time.
//   state | meaning
//   IDLE  | arbitrate; latch winner's addr/len/wr
//   BURST | one SRAM access per cycle, address increments
//   DRAIN | wait RD_LAT cycles for the last read data
//   DONE  | one-cycle done pulse to the owner
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             req_wr_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0]             wr_strobe_o,
    output logic [NUM_REQ-1:0]             rd_valid_o,
    output logic [DATA_W-1:0]              rd_data_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic [ADDR_W-1:0]              sram_addr_o,
    output logic                           sram_ren_o,
    output logic                           sram_wen_o,
    output logic [DATA_W-1:0]              sram_wdata_o,
    input  logic [DATA_W-1:0]              sram_rdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [DRN_W-1:0] drain_q, drain_d;

    logic [RD_LAT-1:0]            rv_q;
    logic [RD_LAT-1:0][IDX_W-1:0] ro_q;

    logic               pick_any;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    wr_d    = req_wr_i[pick_idx];
                    addr_d  = req_addr_i[pick_idx];
                    rem_d   = req_len_i[pick_idx];
                    ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d = (req_len_i[pick_idx] == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    if (wr_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRN_W'(RD_LAT - 1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = DONE;
                else               drain_d = drain_q - DRN_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each issued read travels with its owner so the return lands on the right requester.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rv_q <= '0;
            ro_q <= '0;
        end else begin
            rv_q[0] <= sram_ren_o;
            ro_q[0] <= owner_q;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_q[i] <= rv_q[i-1];
                ro_q[i] <= ro_q[i-1];
            end
        end
    end

    always_comb begin
        grant_o      = '0;
        wr_strobe_o  = '0;
        rd_valid_o   = '0;
        rd_data_o    = '0;
        done_o       = '0;
        sram_addr_o  = '0;
        sram_ren_o   = 1'b0;
        sram_wen_o   = 1'b0;
        sram_wdata_o = '0;
        case (state_q)
            BURST: begin
                grant_o[owner_q] = 1'b1;
                sram_addr_o      = addr_q;
                if (wr_q) begin
                    sram_wen_o           = 1'b1;
                    wr_strobe_o[owner_q] = 1'b1;
                    sram_wdata_o         = req_wdata_i[owner_q];
                end else begin
                    sram_ren_o = 1'b1;
                end
            end
            DRAIN:   grant_o[owner_q] = 1'b1;
            DONE:    done_o[owner_q]  = 1'b1;
            default: ;
        endcase
        if (rv_q[RD_LAT-1]) begin
            rd_valid_o[ro_q[RD_LAT-1]] = 1'b1;
            rd_data_o                  = sram_rdata_i;
        end
    end

endmodule
